// File: rtl/native_axi_master.sv
// Native CPU memory port to AXI4-lite initiator bridge, one transaction in flight.
// Slave error responses and the optional response timeout both complete with mem_error.
module native_axi_master #(
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned TIMEOUT_W      = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_error,
  output logic        mem_axi_awvalid,
  input  logic        mem_axi_awready,
  output logic [31:0] mem_axi_awaddr,
  output logic [2:0]  mem_axi_awprot,
  output logic        mem_axi_wvalid,
  input  logic        mem_axi_wready,
  output logic [31:0] mem_axi_wdata,
  output logic [3:0]  mem_axi_wstrb,
  input  logic        mem_axi_bvalid,
  output logic        mem_axi_bready,
  input  logic [1:0]  mem_axi_bresp,
  output logic        mem_axi_arvalid,
  input  logic        mem_axi_arready,
  output logic [31:0] mem_axi_araddr,
  output logic [2:0]  mem_axi_arprot,
  input  logic        mem_axi_rvalid,
  output logic        mem_axi_rready,
  input  logic [31:0] mem_axi_rdata,
  input  logic [1:0]  mem_axi_rresp
);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WRITE, WRESP, DONE} state_e;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
  } req_t;

  localparam logic [TIMEOUT_W-1:0] TO_LIM = TIMEOUT_W'(TIMEOUT_CYCLES);
  localparam bit                   TO_EN  = (TIMEOUT_CYCLES != 0);

  state_e               state_q;
  req_t                 req_q;
  logic                 awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic                 aw_done_q, w_done_q;
  logic                 ready_q, error_q;
  logic [31:0]          rdata_q;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs, in_xfer, timeout;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^mem_addr[1:0];

  always_comb begin
    aw_hs   = awvalid_q & mem_axi_awready;
    w_hs    = wvalid_q  & mem_axi_wready;
    b_hs    = bready_q  & mem_axi_bvalid;
    ar_hs   = arvalid_q & mem_axi_arready;
    r_hs    = rready_q  & mem_axi_rvalid;
    any_hs  = aw_hs | w_hs | b_hs | ar_hs | r_hs;
    in_xfer = (state_q == RADDR) || (state_q == RDATA) ||
              (state_q == WRITE) || (state_q == WRESP);
    cnt_d   = cnt_q + 1'b1;
    // any handshake landing on the expiry edge wins; the timeout re-arms for the next edge
    timeout = TO_EN && in_xfer && (cnt_d >= TO_LIM) && !any_hs;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      req_q     <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
      rdata_q   <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (mem_valid) begin
            req_q <= '{addr: mem_addr[31:2], wdata: mem_wdata, wstrb: mem_wstrb, instr: mem_instr};
            if (mem_wstrb == 4'h0) begin
              arvalid_q <= 1'b1;
              state_q   <= RADDR;
            end else begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              state_q   <= WRITE;
            end
          end
        end
        DONE: begin
          ready_q <= 1'b0;
          error_q <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          cnt_q <= cnt_d;
          if (timeout) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            ready_q   <= 1'b1;
            error_q   <= 1'b1;
            if (state_q == RADDR || state_q == RDATA) rdata_q <= 32'hDEADBEEF;
            state_q   <= DONE;
          end else begin
            case (state_q)
              RADDR: if (ar_hs) begin
                arvalid_q <= 1'b0;
                rready_q  <= 1'b1;
                state_q   <= RDATA;
              end
              RDATA: if (r_hs) begin
                rready_q <= 1'b0;
                rdata_q  <= mem_axi_rdata;
                error_q  <= (mem_axi_rresp != 2'b00);
                ready_q  <= 1'b1;
                state_q  <= DONE;
              end
              WRITE: begin
                if (aw_hs) begin
                  awvalid_q <= 1'b0;
                  aw_done_q <= 1'b1;
                end
                if (w_hs) begin
                  wvalid_q <= 1'b0;
                  w_done_q <= 1'b1;
                end
                // the edge completing the second handshake also moves on
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
                  bready_q <= 1'b1;
                  state_q  <= WRESP;
                end
              end
              WRESP: if (b_hs) begin
                bready_q <= 1'b0;
                error_q  <= (mem_axi_bresp != 2'b00);
                ready_q  <= 1'b1;
                state_q  <= DONE;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign mem_ready       = ready_q;
  assign mem_error       = error_q;
  assign mem_rdata       = rdata_q;
  assign mem_axi_awvalid = awvalid_q;
  assign mem_axi_awaddr  = {req_q.addr, 2'b00};
  assign mem_axi_awprot  = 3'b000;
  assign mem_axi_wvalid  = wvalid_q;
  assign mem_axi_wdata   = req_q.wdata;
  assign mem_axi_wstrb   = req_q.wstrb;
  assign mem_axi_bready  = bready_q;
  assign mem_axi_arvalid = arvalid_q;
  assign mem_axi_araddr  = {req_q.addr, 2'b00};
  assign mem_axi_arprot  = {req_q.instr, 2'b00};
  assign mem_axi_rready  = rready_q;

endmodule

// File: tb/tb_native_axi_master.sv
// Bench for native_axi_master: delay-programmable AXI4-lite memory slave, vector table,
// reset/timeout sequences and randomized traffic against a word-array memory model.
module tb_native_axi_master;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_valid = 1'b0, mem_instr = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready, mem_error;
  logic [31:0] mem_rdata;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0, bvalid = 1'b0, bready;
  logic        arvalid, arready = 1'b0, rvalid = 1'b0, rready;
  logic [31:0] awaddr, wdata, araddr, rdata = '0;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp = '0, rresp = '0;

  native_axi_master #(.TIMEOUT_CYCLES(8), .TIMEOUT_W(16)) dut (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_error(mem_error),
    .mem_axi_awvalid(awvalid), .mem_axi_awready(awready), .mem_axi_awaddr(awaddr), .mem_axi_awprot(awprot),
    .mem_axi_wvalid(wvalid), .mem_axi_wready(wready), .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb),
    .mem_axi_bvalid(bvalid), .mem_axi_bready(bready), .mem_axi_bresp(bresp),
    .mem_axi_arvalid(arvalid), .mem_axi_arready(arready), .mem_axi_araddr(araddr), .mem_axi_arprot(arprot),
    .mem_axi_rvalid(rvalid), .mem_axi_rready(rready), .mem_axi_rdata(rdata), .mem_axi_rresp(rresp)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, viol = 0, pulses = 0, txns = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // ---------------- slave memory with programmable per-channel delays ----------------
  logic [31:0] smem [256];
  logic [31:0] ref_mem [256];
  int          c_ar = 0, c_r = 0, c_aw = 0, c_w = 0, c_b = 0;
  logic [1:0]  c_rresp = '0, c_bresp = '0;
  logic [31:0] seen_araddr, seen_awaddr;
  logic [2:0]  seen_arprot, seen_awprot;

  initial begin
    for (int i = 0; i < 256; i++) begin
      smem[i]    = 32'hC0DE_0000 + i;
      ref_mem[i] = 32'hC0DE_0000 + i;
    end
  end

  initial begin
    logic        p_arv, p_awv, p_wv, p_rr, p_br, p_mr, r_pend, b_pend, aw_got, w_got;
    logic [31:0] p_araddr, p_awaddr, p_wdata, s_wdata;
    logic [2:0]  p_arprot, p_awprot;
    logic [3:0]  p_wstrb, s_wstrb;
    logic [7:0]  r_idx, w_idx;
    int          ar_wait, aw_wait, w_wait, r_wait, b_wait;
    bit          exempt;
    {p_arv, p_awv, p_wv, p_rr, p_br, p_mr, r_pend, b_pend, aw_got, w_got} = '0;
    {p_araddr, p_awaddr, p_wdata, s_wdata, p_arprot, p_awprot, p_wstrb, s_wstrb, r_idx, w_idx} = '0;
    {ar_wait, aw_wait, w_wait, r_wait, b_wait} = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        {arready, awready, wready, rvalid, bvalid} = '0;
        {r_pend, b_pend, aw_got, w_got} = '0;
        {ar_wait, aw_wait, w_wait, r_wait, b_wait} = '0;
      end else begin
        // a timeout may legally retract a valid without its handshake
        exempt = mem_ready && mem_error;
        if (p_arv && !arready && !exempt && (!arvalid || araddr !== p_araddr || arprot !== p_arprot)) viol++;
        if (p_awv && !awready && !exempt && (!awvalid || awaddr !== p_awaddr || awprot !== p_awprot)) viol++;
        if (p_wv && !wready && !exempt && (!wvalid || wdata !== p_wdata || wstrb !== p_wstrb)) viol++;
        if (bready && (awvalid || wvalid)) viol++;
        if (mem_ready && p_mr) viol++;
        if (mem_ready && !p_mr) pulses++;
        if (p_arv && arready) begin
          if (r_pend) viol++;
          r_pend = 1'b1; r_wait = 0; r_idx = p_araddr[9:2];
        end
        if (p_rr && rvalid) r_pend = 1'b0;
        if (p_awv && awready) begin
          if (aw_got) viol++;
          aw_got = 1'b1; w_idx = p_awaddr[9:2];
        end
        if (p_wv && wready) begin
          if (w_got) viol++;
          w_got = 1'b1; s_wdata = p_wdata; s_wstrb = p_wstrb;
        end
        if (aw_got && w_got) begin
          smem[w_idx] = merge(smem[w_idx], s_wdata, s_wstrb);
          if (b_pend) viol++;
          {aw_got, w_got} = '0;
          b_pend = 1'b1; b_wait = 0;
        end
        if (p_br && bvalid) b_pend = 1'b0;
        arready = arvalid && (ar_wait >= c_ar);
        ar_wait = arvalid ? ar_wait + 1 : 0;
        awready = awvalid && (aw_wait >= c_aw);
        aw_wait = awvalid ? aw_wait + 1 : 0;
        wready  = wvalid && (w_wait >= c_w);
        w_wait  = wvalid ? w_wait + 1 : 0;
        rvalid  = r_pend && (r_wait >= c_r);
        if (r_pend) r_wait++;
        rdata   = smem[r_idx];
        rresp   = c_rresp;
        bvalid  = b_pend && (b_wait >= c_b);
        if (b_pend) b_wait++;
        bresp   = c_bresp;
      end
      if (arvalid) begin seen_araddr = araddr; seen_arprot = arprot; end
      if (awvalid) begin seen_awaddr = awaddr; seen_awprot = awprot; end
      {p_arv, p_awv, p_wv, p_rr, p_br, p_mr} = {arvalid, awvalid, wvalid, rready, bready, mem_ready};
      {p_araddr, p_awaddr, p_wdata, p_arprot, p_awprot, p_wstrb} = {araddr, awaddr, wdata, arprot, awprot, wstrb};
    end
  end

  // ---------------- transaction driver ----------------
  typedef struct {
    bit          wr;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    bit          instr;
    int          ar_d, r_d, aw_d, w_d, b_d;
    logic [1:0]  resp;
    int          exp_lat;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  function automatic vec_t mk(bit wr, logic [31:0] addr, logic [31:0] wd, logic [3:0] ws, bit instr,
                              int ar_d, int r_d, int aw_d, int w_d, int b_d, logic [1:0] resp,
                              int lat, bit err, logic [31:0] rd);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wd; v.wstrb = ws; v.instr = instr;
    v.ar_d = ar_d; v.r_d = r_d; v.aw_d = aw_d; v.w_d = w_d; v.b_d = b_d; v.resp = resp;
    v.exp_lat = lat; v.exp_err = err; v.exp_rdata = rd;
    return v;
  endfunction

  // latency = clock edges from presenting the request until mem_ready is seen
  task automatic do_txn(input vec_t v, input string nm);
    int lat;
    bit got;
    c_ar = v.ar_d; c_r = v.r_d; c_aw = v.aw_d; c_w = v.w_d; c_b = v.b_d;
    c_rresp = v.wr ? 2'b00 : v.resp;
    c_bresp = v.wr ? v.resp : 2'b00;
    seen_araddr = '1; seen_awaddr = '1; seen_arprot = '1; seen_awprot = '1;
    mem_valid = 1'b1; mem_instr = v.instr; mem_addr = v.addr; mem_wdata = v.wdata;
    mem_wstrb = v.wr ? v.wstrb : 4'h0;
    lat = 0; got = 1'b0;
    for (int n = 1; n <= 40 && !got; n++) begin
      @(negedge clk);
      if (n == 1) begin
        mem_addr = $urandom; mem_wdata = $urandom; mem_wstrb = 4'($urandom); mem_instr = 1'($urandom);
      end
      if (mem_ready) begin got = 1'b1; lat = n; end
    end
    mem_valid = 1'b0;
    chk({nm, "_lat"}, lat, v.exp_lat);
    if (got) begin
      chk({nm, "_err"}, {31'b0, mem_error}, {31'b0, v.exp_err});
      if (!v.wr) chk({nm, "_rdata"}, mem_rdata, v.exp_rdata);
      txns++;
    end
    if (!v.wr) begin
      chk({nm, "_araddr"}, seen_araddr, {v.addr[31:2], 2'b00});
      chk({nm, "_arprot"}, {29'b0, seen_arprot}, {29'b0, v.instr, 2'b00});
    end else begin
      chk({nm, "_awaddr"}, seen_awaddr, {v.addr[31:2], 2'b00});
      chk({nm, "_awprot"}, {29'b0, seen_awprot}, 32'h0);
      ref_mem[v.addr[9:2]] = merge(ref_mem[v.addr[9:2]], v.wdata, v.wstrb);
    end
    @(negedge clk);
    chk({nm, "_pulse"}, {31'b0, mem_ready}, 32'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t vt [12];
    vec_t rv;
    int   cnt;
    logic [7:0] idx;
    vt[0]  = mk(0, 32'h0000_1006, 0, 0, 1,  0, 0, 0, 0, 0, 2'b00,  3, 0, 32'hC0DE_0001);
    vt[1]  = mk(1, 32'h0000_2000, 32'hAABB_CCDD, 4'b0110, 0, 0, 0, 0, 4, 0, 2'b00, 7, 0, 0);
    vt[2]  = mk(0, 32'h0000_2000, 0, 0, 0,  0, 0, 0, 0, 0, 2'b00,  3, 0, 32'hC0BB_CC00);
    vt[3]  = mk(1, 32'h0000_2008, 32'h1122_3344, 4'b1111, 0, 0, 0, 3, 0, 1, 2'b00, 7, 0, 0);
    vt[4]  = mk(1, 32'h0000_200C, 32'h5566_7788, 4'b1001, 0, 0, 0, 1, 1, 0, 2'b00, 4, 0, 0);
    vt[5]  = mk(0, 32'h0000_2008, 0, 0, 0,  0, 0, 0, 0, 0, 2'b00,  3, 0, 32'h1122_3344);
    vt[6]  = mk(0, 32'h0000_200E, 0, 0, 0,  0, 0, 0, 0, 0, 2'b00,  3, 0, 32'h55DE_0088);
    vt[7]  = mk(0, 32'h0000_0010, 0, 0, 0,  1, 0, 0, 0, 0, 2'b10,  4, 1, 32'hC0DE_0004);
    vt[8]  = mk(0, 32'h0000_0014, 0, 0, 1,  0, 0, 0, 0, 0, 2'b00,  3, 0, 32'hC0DE_0005);
    vt[9]  = mk(1, 32'h0000_0040, 32'h0, 4'b1111, 0, 0, 0, 0, 0, 0, 2'b10, 3, 1, 0);
    vt[10] = mk(0, 32'h0000_0030, 0, 0, 0, 99, 0, 0, 0, 0, 2'b00,  9, 1, 32'hDEAD_BEEF);
    vt[11] = mk(0, 32'h0000_0034, 0, 0, 0,  7, 0, 0, 0, 0, 2'b00, 10, 0, 32'hC0DE_000D);

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, mem_ready}, 0);
    chk("rst_error", {31'b0, mem_error}, 0);
    chk("rst_rdata", mem_rdata, 0);
    chk("rst_valids", {28'b0, arvalid, awvalid, wvalid, 1'b0}, 0);
    chk("rst_readys", {30'b0, rready, bready}, 0);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) do_txn(vt[i], $sformatf("vec%0d", i));

    // reset asserted while waiting on the write response
    c_aw = 0; c_w = 0; c_b = 6; c_bresp = 2'b00;
    mem_valid = 1'b1; mem_addr = 32'h0000_0050; mem_wdata = 32'hCAFE_F00D; mem_wstrb = 4'hF;
    cnt = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (bready) begin cnt = n; break; end
    end
    chk("wresp_reached", cnt, 2);
    resetn = 1'b0; mem_valid = 1'b0;
    #1;
    chk("rst_mid_bready", {31'b0, bready}, 0);
    chk("rst_mid_ready", {31'b0, mem_ready}, 0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_ready || bready) cnt++;
    end
    chk("rst_no_ready", cnt, 0);
    ref_mem[20] = merge(ref_mem[20], 32'hCAFE_F00D, 4'hF);
    do_txn(mk(0, 32'h0000_0050, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3, 0, ref_mem[20]), "after_rst");

    // randomized traffic against the memory model
    for (int i = 0; i < 40; i++) begin
      idx = 8'($urandom_range(0, 63));
      rv.wr    = 1'($urandom);
      rv.addr  = 32'h0000_4000 | {22'b0, idx, 2'b00} | 32'($urandom_range(0, 3));
      rv.wdata = $urandom;
      rv.wstrb = rv.wr ? 4'($urandom_range(1, 15)) : 4'h0;
      rv.instr = rv.wr ? 1'b0 : 1'($urandom);
      rv.ar_d = $urandom_range(0, 2); rv.r_d = $urandom_range(0, 2);
      rv.aw_d = $urandom_range(0, 2); rv.w_d = $urandom_range(0, 2); rv.b_d = $urandom_range(0, 2);
      rv.resp = ($urandom_range(0, 7) < 5) ? 2'b00 : 2'($urandom_range(1, 3));
      rv.exp_err = (rv.resp != 2'b00);
      rv.exp_rdata = ref_mem[idx];
      rv.exp_lat = rv.wr ? 3 + ((rv.aw_d > rv.w_d) ? rv.aw_d : rv.w_d) + rv.b_d
                         : 3 + rv.ar_d + rv.r_d;
      do_txn(rv, $sformatf("rnd%0d", i));
    end

    chk("protocol_violations", viol, 0);
    chk("ready_pulse_count", pulses, txns);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
